// File: rtl/sensor_frame_receiver.sv
// Buffers packed sensor beats in a small FIFO and re-emits them pixel-serially with frame markers.
// Define SENSOR_RX_STATS_EN to add per-frame min/max/sum statistics outputs.
module sensor_frame_receiver #(
  parameter int PIXEL_BITS = 8,
  parameter int BUS_PIXELS = 8,
  parameter int ROW_BEATS  = 3,
  parameter int ROWS       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [BUS_PIXELS*PIXEL_BITS-1:0] in_data,
  input  logic                             in_frame_end,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PIXEL_BITS-1:0]            out_pixel,
  output logic                             out_sof,
  output logic                             out_eol,
  output logic                             out_eof,
  output logic                             overflow,
  output logic                             frame_err
`ifdef SENSOR_RX_STATS_EN
  ,
  output logic [PIXEL_BITS-1:0]            stat_min,
  output logic [PIXEL_BITS-1:0]            stat_max,
  output logic [$clog2(ROWS*ROW_BEATS*BUS_PIXELS*((1<<PIXEL_BITS)-1)+1)-1:0] stat_sum,
  output logic                             stat_valid
`endif
);

  localparam int BEAT_W      = BUS_PIXELS * PIXEL_BITS;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int PTR_W       = AW + 1;
  localparam int FRAME_BEATS = ROWS * ROW_BEATS;
  localparam int CNT_W       = $clog2(FRAME_BEATS + 1);
  localparam int PIX_W       = (BUS_PIXELS > 1) ? $clog2(BUS_PIXELS) : 1;
  localparam int BEAT_IDX_W  = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_SERIAL = 1'b1;

  logic [BEAT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, fill, fill_next;
  logic [0:0]            state;
  logic [PIX_W-1:0]      pix_idx;
  logic [BEAT_IDX_W-1:0] beat_idx;
  logic [ROW_W-1:0]      row_idx;
  logic [CNT_W-1:0]      in_cnt, cnt_inc;
  logic                  full, handshake, last_pix, last_beat, last_row, pop, push;
  logic [BEAT_W-1:0]     head;
  logic [PIXEL_BITS-1:0] head_pix [BUS_PIXELS];

  // A full FIFO still takes a beat when the head is popped in the same cycle.
  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == PTR_W'(FIFO_DEPTH));
  assign out_valid = (state == ST_SERIAL);
  assign handshake = out_valid & out_ready;
  assign last_pix  = (pix_idx == PIX_W'(BUS_PIXELS - 1));
  assign last_beat = (beat_idx == BEAT_IDX_W'(ROW_BEATS - 1));
  assign last_row  = (row_idx == ROW_W'(ROWS - 1));
  assign pop       = handshake & last_pix;
  assign push      = in_valid & (~full | pop);
  assign fill_next = fill + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  for (genvar k = 0; k < BUS_PIXELS; k++) begin : g_pix
    assign head_pix[k] = head[k*PIXEL_BITS +: PIXEL_BITS];
  end

  assign out_pixel = out_valid ? head_pix[pix_idx] : '0;
  assign out_sof   = out_valid & (pix_idx == '0) & (beat_idx == '0) & (row_idx == '0);
  assign out_eol   = out_valid & last_pix & last_beat;
  assign out_eof   = out_eol & last_row;

  // Next state looks at the post-edge fill so a fresh beat is presented right after its write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= ST_EMPTY;
      pix_idx  <= '0;
      beat_idx <= '0;
      row_idx  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state <= (fill_next != '0) ? ST_SERIAL : ST_EMPTY;
      if (handshake) pix_idx <= last_pix ? '0 : pix_idx + 1'b1;
      if (pop) begin
        beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
        if (last_beat) row_idx <= last_row ? '0 : row_idx + 1'b1;
      end
    end
  end

  assign cnt_inc = (in_cnt == CNT_W'(FRAME_BEATS)) ? in_cnt : in_cnt + 1'b1;

  // A beat arriving together with the frame-end pulse belongs to the ending frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (in_valid & ~push) overflow <= 1'b1;
      if (in_frame_end) begin
        if ((in_valid ? cnt_inc : in_cnt) != CNT_W'(FRAME_BEATS)) frame_err <= 1'b1;
        in_cnt <= '0;
      end else if (in_valid) begin
        in_cnt <= cnt_inc;
      end
    end
  end

`ifdef SENSOR_RX_STATS_EN
  localparam int SUM_W = $clog2(ROWS*ROW_BEATS*BUS_PIXELS*((1<<PIXEL_BITS)-1)+1);

  logic [PIXEL_BITS-1:0] acc_min, acc_max, nxt_min, nxt_max;
  logic [SUM_W-1:0]      acc_sum, nxt_sum;

  always_comb begin
    nxt_min = out_sof ? out_pixel : ((out_pixel < acc_min) ? out_pixel : acc_min);
    nxt_max = out_sof ? out_pixel : ((out_pixel > acc_max) ? out_pixel : acc_max);
    nxt_sum = out_sof ? SUM_W'(out_pixel) : acc_sum + SUM_W'(out_pixel);
  end

  // Published values include the eof pixel itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_min    <= '0;
      acc_max    <= '0;
      acc_sum    <= '0;
      stat_min   <= '0;
      stat_max   <= '0;
      stat_sum   <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= handshake & out_eof;
      if (handshake) begin
        acc_min <= nxt_min;
        acc_max <= nxt_max;
        acc_sum <= nxt_sum;
        if (out_eof) begin
          stat_min <= nxt_min;
          stat_max <= nxt_max;
          stat_sum <= nxt_sum;
        end
      end
    end
  end
`endif

endmodule

// File: doc/sensor_frame_receiver.md
# sensor_frame_receiver

Consumes the packed pixel bursts that the sensor top-level output buffer drives, 8 pixels × 8 bits per beat, and re-emits them as a pixel-serial stream with valid/ready flow control and frame markers. Beats pass through a small beat FIFO. An unpacker serialises each beat and tags start-of-frame, end-of-line and end-of-frame. Frame-length and overflow errors are flagged, and optional per-frame statistics are produced. The block sits directly downstream of the sensor top, in the `clk` domain, after an external synchroniser that turns the burst clock into a one-cycle `in_valid` strobe.

## Interface

Parameters:
- `PIXEL_BITS`, 8: bits per pixel.
- `BUS_PIXELS`, 8: pixels per input beat.
- `ROW_BEATS`, 3: beats per sensor row (24-pixel rows).
- `ROWS`, 3: rows per frame.
- `FIFO_DEPTH`, 4: beat FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset. Asynchronous, active-high.
- `in_valid`, input, 1: one-cycle strobe; one beat present on `in_data`.
- `in_data`, input, BUS_PIXELS×PIXEL_BITS: beat. Pixel k is at `[k*PIXEL_BITS +: PIXEL_BITS]`; pixel 0 is emitted first.
- `in_frame_end`, input, 1: one-cycle pulse, synchronised FRAME_FINISHED.
- `out_valid`, output, 1: `out_pixel` and the markers are valid.
- `out_ready`, input, 1: downstream accepts.
- `out_pixel`, output, PIXEL_BITS: current pixel.
- `out_sof`, output, 1: first pixel of a frame.
- `out_eol`, output, 1: last pixel of a row.
- `out_eof`, output, 1: last pixel of a frame.
- `overflow`, output, 1: sticky; a beat was dropped.
- `frame_err`, output, 1: sticky; wrong beat count at a frame end.

## Operation

- **Write side**
  - A beat is written when `in_valid` is high and the FIFO is not full.
  - A beat is also written when the FIFO is full and a pop happens in the same cycle.
  - Otherwise the beat is dropped and `overflow` is set.
  - The input beat counter `in_cnt` increments on every strobe, dropped or not, and saturates at ROWS×ROW_BEATS.
- **Frame end**
  - On `in_frame_end`, `frame_err` is set if `in_cnt` ≠ ROWS×ROW_BEATS, counting the same-cycle beat if any.
  - `in_cnt` then clears to 0. The same-cycle beat counts toward the ending frame.
- **Unpacker states**
  - EMPTY: `out_valid` = 0. Leaves for SERIAL when the FIFO is non-empty.
  - SERIAL: presents pixel `pix_idx` of the FIFO head beat.
  - Each handshake (`out_valid & out_ready`) advances `pix_idx`.
  - On the handshake with `pix_idx` = BUS_PIXELS−1, the head beat is popped and `pix_idx` wraps to 0. The state returns to EMPTY if the FIFO becomes empty.
- **Position counters**
  - `beat_idx` (0..ROW_BEATS−1) and `row_idx` (0..ROWS−1) advance on each pop and wrap.
  - `out_sof` = `pix_idx`==0 & `beat_idx`==0 & `row_idx`==0.
  - `out_eol` = last pixel of the last beat of a row.
  - `out_eof` = `out_eol` & `row_idx`==ROWS−1.
  - The markers are combinational from the counters and are qualified by `out_valid`.
- **Flag clearing**: `overflow` and `frame_err` clear only on `reset`.
- **Frame framing**: frame position comes from the output counters, not from `in_frame_end`. A short frame misaligns following frames until reset, and `frame_err` flags it.

## Timing

- **Reset values**
  - All outputs are 0.
  - FIFO is empty; `pix_idx`, `beat_idx`, `row_idx` and `in_cnt` are 0; state is EMPTY.
- **Reset mid-frame**: discards all FIFO content immediately (asynchronous).
- **Latency**: a beat written at edge N gives `out_valid` = 1 after edge N, with pixel 0 of that beat, if the FIFO was empty.
- **Throughput**: one pixel per cycle while `out_ready` = 1. A beat drains in BUS_PIXELS cycles.
- **Stall**: while `out_valid` & !`out_ready`, `out_pixel` and the markers hold stable.
- **Backpressure**: the sensor has no backpressure. With continuous `out_ready`, FIFO_DEPTH=4 absorbs 3-beat bursts spaced ≥ 24 cycles apart.

## Configuration

- **`SENSOR_RX_STATS_EN` defined**: adds the following outputs.
  - `stat_min` (PIXEL_BITS) and `stat_max` (PIXEL_BITS).
  - `stat_sum`, width $clog2(ROWS×ROW_BEATS×BUS_PIXELS×(2^PIXEL_BITS−1)+1) (15 bits by default).
  - `stat_valid`: one-cycle pulse.
- **Accumulation**
  - Statistics cover every handshaken pixel.
  - Accumulators re-initialise on the `out_sof` handshake: min=pixel, max=pixel, sum=pixel.
- **Publishing**
  - On the `out_eof` handshake the final values, including the eof pixel, are registered into the `stat_*` outputs.
  - `stat_valid` pulses in the cycle after that handshake.
  - `stat_*` outputs reset to 0.
- **Not defined**: the ports and logic are absent; the remaining behaviour is identical.

## Test plan

- **Single beat**: after reset, `in_data` = 0x0706050403020100 with `in_valid` for 1 cycle and `out_ready` = 1 → `out_valid` from the next cycle. `out_pixel` = 0,1,…,7 on consecutive cycles, `out_sof` on pixel 0, then `out_valid` = 0.
- **Full frame**: 9 beats in bursts of 3 beats, bursts 30 cycles apart, then `in_frame_end` → 72 pixels, with `out_eol` on pixels 23, 47, 71 and `out_eof` only on 71. `frame_err` = 0.
  - With `SENSOR_RX_STATS_EN`: all pixels 0x10 except a single 0xF0 → `stat_min`=0x10, `stat_max`=0xF0, `stat_sum`=71×16+240=1376, `stat_valid` pulse one cycle after the eof handshake.
- **Stall**: `out_ready` = 0 while 4 beats arrive, then a 5th beat → `overflow` = 1. Output shows pixel 0 held stable; releasing `out_ready` drains exactly 32 pixels.
- **Full push with pop**: FIFO full, `in_valid` in the cycle of the pixel-7 handshake → beat accepted, `overflow` stays 0.
- **Short frame**: 8 beats then `in_frame_end` → `frame_err` = 1. `in_frame_end` in the same cycle as the 9th beat → `frame_err` stays 0.
- **Reset mid-frame**: assert `reset` after 2 beats → outputs 0 at once. A following full frame starts with `out_sof` on its first pixel.
